// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 slice model: operand-select encodings,
// OPMODE bit positions and datapath widths.
package dsp48a1_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN   = 5;
  localparam int OP_SUB   = 7;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline stage: a clock-enabled register with async active-low
// reset, or a straight wire when EN_REG is 0.
module dsp_pipe_reg #(
  parameter int WIDTH  = 1,
  parameter bit EN_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q_r <= '0;
    else if (ce)
      q_r <= d;
  end

  assign q = EN_REG ? q_r : d;

endmodule

// File: rtl/dsp_post_accum.sv
// Post-adder/accumulator stage of a DSP48A1 slice: X/Z operand muxes, add or
// subtract with carry-in, optional P/OPMODE/carry-in pipeline registers.
module dsp_post_accum
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH      = P_W,
  parameter int MWIDTH     = M_W,
  parameter int PREG       = 1,
  parameter int CARRYINREG = 1,
  parameter int OPMODEREG  = 1,
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CEP,
  input  logic              CECARRYIN,
  input  logic              CEOPMODE,
  input  logic [7:0]        OPMODE,
  input  logic [MWIDTH-1:0] M,
  input  logic [WIDTH-1:0]  C,
  input  logic [WIDTH-1:0]  D_A_B,
  input  logic [WIDTH-1:0]  PCIN,
  input  logic              CARRYIN,
  input  logic              VALID_IN,
  output logic [WIDTH-1:0]  P,
  output logic [WIDTH-1:0]  PCOUT,
  output logic              CARRYOUT,
  output logic              CARRYOUTF,
  output logic              VALID_OUT
);

  logic [7:0]       opmode_q;
  logic             cin_d;
  logic             cin_q;
  logic [WIDTH-1:0] p_q;
  logic             cout_q;
  logic             valid_q;
  logic [WIDTH-1:0] xv;
  logic [WIDTH-1:0] zv;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   add_full;
  logic             cout;
  x_sel_e           x_sel;
  z_sel_e           z_sel;
  logic             unused_ctrl_bits;

  dsp_pipe_reg #(.WIDTH(8), .EN_REG(OPMODEREG != 0)) u_opmode_reg (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce    (CEOPMODE),
    .d     (OPMODE),
    .q     (opmode_q)
  );

  assign cin_d = (CARRYINSEL == "CARRYIN") ? CARRYIN : opmode_q[OP_CIN];

  dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG != 0)) u_cin_reg (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce    (CECARRYIN),
    .d     (cin_d),
    .q     (cin_q)
  );

  assign x_sel = x_sel_e'(opmode_q[OP_X_LSB +: 2]);
  assign z_sel = z_sel_e'(opmode_q[OP_Z_LSB +: 2]);

  // Without PREG the P feedback would form a combinational loop, so it reads as 0.
  always_comb begin
    xv = '0;
    case (x_sel)
      X_M:     xv = {{(WIDTH-MWIDTH){1'b0}}, M};
      X_P:     xv = (PREG != 0) ? p_q : '0;
      X_DAB:   xv = D_A_B;
      default: xv = '0;
    endcase

    zv = '0;
    case (z_sel)
      Z_PCIN:  zv = PCIN;
      Z_P:     zv = (PREG != 0) ? p_q : '0;
      Z_C:     zv = C;
      default: zv = '0;
    endcase

    add_full = {1'b0, zv} + {1'b0, xv} + {{WIDTH{1'b0}}, cin_q};
    if (opmode_q[OP_SUB]) begin
      sum  = zv - xv - {{(WIDTH-1){1'b0}}, cin_q};
      cout = 1'b0;
    end else begin
      sum  = add_full[WIDTH-1:0];
      cout = add_full[WIDTH];
    end
  end

  dsp_pipe_reg #(.WIDTH(WIDTH + 2), .EN_REG(PREG != 0)) u_p_reg (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce    (CEP),
    .d     ({VALID_IN, cout, sum}),
    .q     ({valid_q, cout_q, p_q})
  );

  assign P         = p_q;
  assign PCOUT     = p_q;
  assign CARRYOUT  = cout_q;
  assign CARRYOUTF = cout_q;
  assign VALID_OUT = valid_q;

  assign unused_ctrl_bits = ^{opmode_q[6], opmode_q[4], opmode_q[OP_CIN], CARRYIN};

  p_loop_illegal: assert property (@(posedge CLK) disable iff (!RST_N)
      (PREG != 0) || ((x_sel != X_P) && (z_sel != Z_P)))
    else $error("dsp_post_accum: P selected as operand while PREG=0");

endmodule

// File: tb/tb_dsp_post_accum.sv
// Bench for dsp_post_accum: directed vector table, multi-cycle sequences and a
// randomized run against an arithmetic reference model.
module tb_dsp_post_accum;

  logic        CLK;
  logic        RST_N;
  logic        CEP;
  logic        CECARRYIN;
  logic        CEOPMODE;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] C;
  logic [47:0] D_A_B;
  logic [47:0] PCIN;
  logic        CARRYIN;
  logic        VALID_IN;

  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF, VALID_OUT;
  logic [47:0] p_cr, pcout_cr, p_cn, pcout_cn;
  logic        co_cr, cof_cr, v_cr, co_cn, cof_cn, v_cn;

  int checks = 0;
  int errors = 0;

  dsp_post_accum dut (
    .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .OPMODE(OPMODE), .M(M), .C(C), .D_A_B(D_A_B), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .VALID_IN(VALID_IN), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT),
    .CARRYOUTF(CARRYOUTF), .VALID_OUT(VALID_OUT)
  );

  dsp_post_accum #(.CARRYINSEL("CARRYIN"), .CARRYINREG(1)) dut_cin_reg (
    .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .OPMODE(OPMODE), .M(M), .C(C), .D_A_B(D_A_B), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .VALID_IN(VALID_IN), .P(p_cr), .PCOUT(pcout_cr), .CARRYOUT(co_cr),
    .CARRYOUTF(cof_cr), .VALID_OUT(v_cr)
  );

  dsp_post_accum #(.CARRYINSEL("CARRYIN"), .CARRYINREG(0)) dut_cin_nreg (
    .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .OPMODE(OPMODE), .M(M), .C(C), .D_A_B(D_A_B), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .VALID_IN(VALID_IN), .P(p_cn), .PCOUT(pcout_cn), .CARRYOUT(co_cn),
    .CARRYOUTF(cof_cn), .VALID_OUT(v_cn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] dab;
    logic [47:0] pcin;
    logic        vin;
    logic [47:0] p;
    logic        co;
    logic        v;
  } vec_t;

  vec_t tbl[8];

  // Reference model state for the randomized run
  logic [7:0]  op_hist[$];
  logic [47:0] mp;
  logic        mco;
  logic        mv;

  task automatic model_step(input logic [7:0] op_eff, input logic cin);
    logic [47:0] x, z;
    logic [48:0] full;
    case (op_eff[1:0])
      2'd0: x = 48'd0;
      2'd1: x = {12'd0, M};
      2'd2: x = mp;
      default: x = D_A_B;
    endcase
    case (op_eff[3:2])
      2'd0: z = 48'd0;
      2'd1: z = PCIN;
      2'd2: z = mp;
      default: z = C;
    endcase
    if (CEP) begin
      if (op_eff[7]) begin
        mp  = z - x - {47'd0, cin};
        mco = 1'b0;
      end else begin
        full = {1'b0, z} + {1'b0, x} + {48'd0, cin};
        mp   = full[47:0];
        mco  = full[48];
      end
      mv = VALID_IN;
    end
  endtask

  initial begin
    tbl[0] = '{8'h0D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b1, 48'd15, 1'b0, 1'b1};
    tbl[1] = '{8'hAF, 36'd0, 48'd100, 48'd30, 48'd0, 1'b1, 48'd69, 1'b0, 1'b1};
    tbl[2] = '{8'h0D, 36'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b1, 48'd0, 1'b1, 1'b1};
    tbl[3] = '{8'h07, 36'd9, 48'd77, 48'h123, 48'h1000, 1'b0, 48'h1123, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 36'd5, 48'd0, 48'd0, 48'd0, 1'b1, 48'hFFFF_FFFF_FFFB, 1'b0, 1'b1};
    tbl[5] = '{8'h20, 36'd5, 48'd3, 48'd4, 48'd6, 1'b1, 48'd1, 1'b0, 1'b1};
    tbl[6] = '{8'h2F, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b1, 48'd0, 1'b1, 1'b1};
    tbl[7] = '{8'h0D, 36'hF_FFFF_FFFF, 48'd1, 48'd0, 48'd0, 1'b1, 48'h10_0000_0000, 1'b0, 1'b1};

    RST_N = 1'b0; CEP = 1'b1; CECARRYIN = 1'b1; CEOPMODE = 1'b1;
    OPMODE = 8'h00; M = '0; C = '0; D_A_B = '0; PCIN = '0; CARRYIN = 1'b0; VALID_IN = 1'b0;
    tick();
    chk("reset_p", {16'd0, P}, 64'd0);
    chk("reset_valid", {63'd0, VALID_OUT}, 64'd0);
    tick();
    RST_N = 1'b1;

    // Directed vectors: hold each set long enough to flush OPMODE and carry-in registers
    for (int i = 0; i < 8; i++) begin
      OPMODE = tbl[i].op; M = tbl[i].m; C = tbl[i].c; D_A_B = tbl[i].dab;
      PCIN = tbl[i].pcin; VALID_IN = tbl[i].vin; CEP = 1'b1;
      repeat (3) tick();
      chk($sformatf("vec%0d_p", i), {16'd0, P}, {16'd0, tbl[i].p});
      chk($sformatf("vec%0d_pcout", i), {16'd0, PCOUT}, {16'd0, tbl[i].p});
      chk($sformatf("vec%0d_carryout", i), {63'd0, CARRYOUT}, {63'd0, tbl[i].co});
      chk($sformatf("vec%0d_carryoutf", i), {63'd0, CARRYOUTF}, {63'd0, tbl[i].co});
      chk($sformatf("vec%0d_valid", i), {63'd0, VALID_OUT}, {63'd0, tbl[i].v});
    end

    // Accumulate M=3 four times from P=0, then hold with CEP low
    OPMODE = 8'h00; CEP = 1'b1;
    repeat (2) tick();
    chk("acc_start_p", {16'd0, P}, 64'd0);
    CEP = 1'b0; OPMODE = 8'h09; M = 36'd3; VALID_IN = 1'b1;
    repeat (2) tick();
    CEP = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("acc%0d_p", i), {16'd0, P}, 64'(3 * i));
      chk($sformatf("acc%0d_valid", i), {63'd0, VALID_OUT}, 64'd1);
    end
    CEP = 1'b0; VALID_IN = 1'b0; M = 36'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("hold%0d_p", i), {16'd0, P}, 64'd12);
      chk($sformatf("hold%0d_valid", i), {63'd0, VALID_OUT}, 64'd1);
    end

    // Async reset mid-cycle with CEP high, then release mid-accumulation
    CEP = 1'b1; VALID_IN = 1'b1;
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_p", {16'd0, P}, 64'd0);
    chk("async_rst_carryout", {63'd0, CARRYOUT}, 64'd0);
    chk("async_rst_valid", {63'd0, VALID_OUT}, 64'd0);
    tick();
    chk("rst_held_p", {16'd0, P}, 64'd0);
    #3 RST_N = 1'b1; CEP = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("post_rst%0d_p", i), {16'd0, P}, 64'd0);
      chk($sformatf("post_rst%0d_valid", i), {63'd0, VALID_OUT}, 64'd0);
    end
    CEP = 1'b1;
    tick();
    chk("restart_p", {16'd0, P}, 64'd7);
    chk("restart_valid", {63'd0, VALID_OUT}, 64'd1);

    // Carry-in latency from the CARRYIN port, registered vs bypassed
    OPMODE = 8'h0C; C = '0; M = '0; CARRYIN = 1'b0;
    repeat (3) tick();
    CARRYIN = 1'b1;
    tick();
    CARRYIN = 1'b0;
    chk("cin_nreg_first_p", {16'd0, p_cn}, 64'd1);
    chk("cin_reg_first_p", {16'd0, p_cr}, 64'd0);
    tick();
    chk("cin_nreg_second_p", {16'd0, p_cn}, 64'd0);
    chk("cin_reg_second_p", {16'd0, p_cr}, 64'd1);

    // Randomized run against the arithmetic model
    RST_N = 1'b0;
    #2 RST_N = 1'b1;
    mp = '0; mco = 1'b0; mv = 1'b0;
    op_hist = {};
    op_hist.push_back(8'h00);
    op_hist.push_back(8'h00);
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic [7:0] op_eff;
      logic       cin;
      OPMODE   = 8'($urandom);
      M        = {4'($urandom), 32'($urandom)};
      C        = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      D_A_B    = {16'($urandom), 32'($urandom)};
      PCIN     = {16'($urandom), 32'($urandom)};
      CARRYIN  = 1'($urandom);
      VALID_IN = 1'($urandom);
      CEP      = ($urandom_range(0, 3) != 0);
      op_hist.push_back(OPMODE);
      op_eff = op_hist[op_hist.size() - 2];
      cin    = op_hist[op_hist.size() - 3][5];
      model_step(op_eff, cin);
      tick();
      chk($sformatf("rnd%0d_p", cyc), {16'd0, P}, {16'd0, mp});
      chk($sformatf("rnd%0d_carryout", cyc), {63'd0, CARRYOUT}, {63'd0, mco});
      chk($sformatf("rnd%0d_valid", cyc), {63'd0, VALID_OUT}, {63'd0, mv});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
